// File: rtl/buzzer_ctl_poly_if.sv
// rtl/buzzer_ctl_poly_if.sv - control and audio bundle for the polyphonic buzzer
// The sequencer drives through master; the tone generator sits on slave.
interface buzzer_ctl_poly_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 22,
  parameter int VOL_W  = 4,
  parameter int DUR_W  = 12,
  parameter int AMP_W  = 16
);
  logic                    tick;
  logic [NUM_CH*DIV_W-1:0] note_div;
  logic [NUM_CH*VOL_W-1:0] volume;
  logic [NUM_CH*DUR_W-1:0] dur;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       busy;
  logic [AMP_W-1:0]        audio_out;

  modport master (
    output tick, note_div, volume, dur, start, stop,
    input  busy, audio_out
  );

  modport slave (
    input  tick, note_div, volume, dur, start, stop,
    output busy, audio_out
  );
endinterface

// File: rtl/buzzer_ctl_poly.sv
// rtl/buzzer_ctl_poly.sv - multi-channel square-wave tone generator with saturating mixer
// Each channel runs its own divider and duration timer; contributions are summed into one PCM sample.
module buzzer_ctl_poly #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 22,
  parameter int VOL_W  = 4,
  parameter int DUR_W  = 12,
  parameter int AMP_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  buzzer_ctl_poly_if.slave   bus
);
  localparam int SUM_W = AMP_W + $clog2(NUM_CH) + 1;
  localparam int SHIFT = AMP_W - 1 - VOL_W;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (AMP_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] phase_q, phase_d;
  logic [NUM_CH-1:0] inf_q, inf_d;
  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_d [NUM_CH];
  logic [DUR_W-1:0]  durc_q [NUM_CH];
  logic [DUR_W-1:0]  durc_d [NUM_CH];
  logic [AMP_W-1:0]  audio_out_q, audio_out_d;

  logic [DIV_W-1:0]        nd [NUM_CH];
  logic [DUR_W-1:0]        du [NUM_CH];
  logic signed [SUM_W-1:0] amp [NUM_CH];
  logic signed [SUM_W-1:0] sum;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign nd[c]  = bus.note_div[c*DIV_W +: DIV_W];
    assign du[c]  = bus.dur[c*DUR_W +: DUR_W];
    assign amp[c] = $signed(SUM_W'(bus.volume[c*VOL_W +: VOL_W]) << SHIFT);
  end

  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    inf_d   = inf_q;
    cnt_d   = cnt_q;
    durc_d  = durc_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.start[c]) begin
        busy_d[c]  = 1'b1;
        cnt_d[c]   = '0;
        phase_d[c] = 1'b0;
        durc_d[c]  = du[c];
        inf_d[c]   = (du[c] == '0);
      end else if (bus.stop[c]) begin
        busy_d[c]  = 1'b0;
        cnt_d[c]   = '0;
        phase_d[c] = 1'b0;
      end else if (busy_q[c]) begin
        if (bus.tick && !inf_q[c] && durc_q[c] == DUR_W'(1)) begin
          busy_d[c]  = 1'b0;
          cnt_d[c]   = '0;
          phase_d[c] = 1'b0;
          durc_d[c]  = '0;
        end else begin
          if (bus.tick && !inf_q[c]) begin
            durc_d[c] = durc_q[c] - DUR_W'(1);
          end
          // >= rather than == so a lowered divider cuts the half-period short instead of wrapping
          if (nd[c] != '0) begin
            if (cnt_q[c] >= nd[c]) begin
              cnt_d[c]   = '0;
              phase_d[c] = ~phase_q[c];
            end else begin
              cnt_d[c] = cnt_q[c] + DIV_W'(1);
            end
          end
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (busy_q[c] && nd[c] != '0) begin
        sum = phase_q[c] ? sum + amp[c] : sum - amp[c];
      end
    end
    if (sum > SAT_MAX) begin
      audio_out_d = SAT_MAX[AMP_W-1:0];
    end else if (sum < SAT_MIN) begin
      audio_out_d = SAT_MIN[AMP_W-1:0];
    end else begin
      audio_out_d = sum[AMP_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      phase_q     <= '0;
      inf_q       <= '0;
      cnt_q       <= '{default: '0};
      durc_q      <= '{default: '0};
      audio_out_q <= '0;
    end else begin
      busy_q      <= busy_d;
      phase_q     <= phase_d;
      inf_q       <= inf_d;
      cnt_q       <= cnt_d;
      durc_q      <= durc_d;
      audio_out_q <= audio_out_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.audio_out = audio_out_q;
endmodule

// File: tb/tb_buzzer_ctl_poly.sv
// tb/tb_buzzer_ctl_poly.sv - scoreboard bench for buzzer_ctl_poly
// Expected samples are queued per scenario and drained one per clock.
module tb_buzzer_ctl_poly;
  localparam int NUM_CH = 2;
  localparam int DIV_W  = 22;
  localparam int VOL_W  = 4;
  localparam int DUR_W  = 12;
  localparam int AMP_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  buzzer_ctl_poly_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .VOL_W(VOL_W), .DUR_W(DUR_W), .AMP_W(AMP_W)) bus ();

  buzzer_ctl_poly #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .VOL_W(VOL_W), .DUR_W(DUR_W), .AMP_W(AMP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int                audio;
    logic [NUM_CH-1:0] busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input int nd, input int vol, input int du);
    bus.note_div[c*DIV_W +: DIV_W] = DIV_W'(nd);
    bus.volume[c*VOL_W +: VOL_W]   = VOL_W'(vol);
    bus.dur[c*DUR_W +: DUR_W]      = DUR_W'(du);
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] sp, input logic tk);
    bus.start = st;
    bus.stop  = sp;
    bus.tick  = tk;
    cyc();
    bus.start = '0;
    bus.stop  = '0;
    bus.tick  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.tick     = 1'b0;
    bus.start    = '0;
    bus.stop     = '0;
    bus.note_div = '0;
    bus.volume   = '0;
    bus.dur      = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  function automatic int amp_at(input int k, input int a);
    return ((k / 4) % 2) ? a : -a;
  endfunction

  function automatic exp_t mk(input int a, input logic [NUM_CH-1:0] b);
    exp_t r;
    r.audio = a;
    r.busy  = b;
    return r;
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    bus.tick = 1'b0; bus.start = '0; bus.stop = '0;
    bus.note_div = '0; bus.volume = '0; bus.dur = '0;
    #2;
    checks++;
    if (bus.audio_out !== '0 || bus.busy !== '0) begin
      errors++;
      $display("FAIL reset_held audio_out=%0d busy=%b expected 0/00", $signed(bus.audio_out), bus.busy);
    end
    repeat (3) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) exp_q.push_back(mk(0, 2'b00));
    for (int i = 0; i < 100; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (bus.audio_out !== AMP_W'(e.audio) || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL reset_idle cyc %0d audio_out=%0d busy=%b expected %0d/%b", i, $signed(bus.audio_out), bus.busy, e.audio, e.busy);
      end
    end
  endtask

  task automatic test_single_tone();
    do_reset();
    set_ch(0, 3, 15, 0);
    pulse(2'b01, 2'b00, 1'b0);
    checks++;
    if (bus.busy !== 2'b01) begin
      errors++;
      $display("FAIL tone_busy busy=%b expected 01", bus.busy);
    end
    for (int i = 1; i <= 24; i++) exp_q.push_back(mk(amp_at(i - 1, 30720), 2'b01));
    for (int i = 1; i <= 24; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (bus.audio_out !== AMP_W'(e.audio) || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL tone cyc %0d audio_out=%0d busy=%b expected %0d/%b", i, $signed(bus.audio_out), bus.busy, e.audio, e.busy);
      end
    end
  endtask

  task automatic test_mix();
    do_reset();
    set_ch(0, 3, 15, 0);
    set_ch(1, 3, 15, 0);
    pulse(2'b11, 2'b00, 1'b0);
    for (int i = 1; i <= 24; i++) exp_q.push_back(mk((((i - 1) / 4) % 2) ? 32767 : -32768, 2'b11));
    for (int i = 1; i <= 24; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (bus.audio_out !== AMP_W'(e.audio) || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL mix_sat cyc %0d audio_out=%0d busy=%b expected %0d/%b", i, $signed(bus.audio_out), bus.busy, e.audio, e.busy);
      end
      if (i == 12) bus.volume[VOL_W +: VOL_W] = VOL_W'(1);
    end

    do_reset();
    set_ch(0, 3, 15, 0);
    set_ch(1, 3, 1, 0);
    pulse(2'b01, 2'b00, 1'b0);
    for (int i = 1; i <= 20; i++)
      exp_q.push_back(mk((i <= 4) ? -30720 : ((((i - 5) / 4) % 2) ? -28672 : 28672), (i >= 4) ? 2'b11 : 2'b01));
    for (int i = 1; i <= 20; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (bus.audio_out !== AMP_W'(e.audio) || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL mix_opposite cyc %0d audio_out=%0d busy=%b expected %0d/%b", i, $signed(bus.audio_out), bus.busy, e.audio, e.busy);
      end
      if (i == 3) bus.start = 2'b10;
      if (i == 4) bus.start = 2'b00;
    end
  endtask

  task automatic test_duration(input int off);
    int end_edge;
    end_edge = (off == 0) ? 30 : off + 20;
    do_reset();
    set_ch(0, 3, 15, 3);
    pulse(2'b01, 2'b00, off == 0);
    for (int i = 1; i <= 40; i++)
      exp_q.push_back(mk((i <= end_edge) ? amp_at(i - 1, 30720) : 0, (i < end_edge) ? 2'b01 : 2'b00));
    for (int i = 1; i <= 40; i++) begin
      cyc();
      bus.tick = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (bus.audio_out !== AMP_W'(e.audio) || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL duration_off%0d cyc %0d audio_out=%0d busy=%b expected %0d/%b", off, i, $signed(bus.audio_out), bus.busy, e.audio, e.busy);
      end
      bus.tick = ((i + 1) % 10 == off);
    end
    bus.tick = 1'b0;
  endtask

  task automatic test_div_change();
    do_reset();
    set_ch(0, 1000, 15, 0);
    pulse(2'b01, 2'b00, 1'b0);
    for (int i = 1; i <= 720; i++)
      exp_q.push_back(mk((i <= 501) ? -30720 : ((((i - 502) / 101) % 2) ? -30720 : 30720), 2'b01));
    for (int i = 1; i <= 720; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (bus.audio_out !== AMP_W'(e.audio) || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL div_change cyc %0d audio_out=%0d busy=%b expected %0d/%b", i, $signed(bus.audio_out), bus.busy, e.audio, e.busy);
      end
      if (i == 500) bus.note_div[0 +: DIV_W] = DIV_W'(100);
    end
  endtask

  task automatic test_start_stop();
    do_reset();
    set_ch(0, 3, 15, 0);
    pulse(2'b01, 2'b01, 1'b0);
    checks++;
    if (bus.busy !== 2'b01) begin
      errors++;
      $display("FAIL start_stop_same busy=%b expected 01", bus.busy);
    end
    for (int i = 1; i <= 12; i++)
      exp_q.push_back(mk((i <= 7) ? amp_at(i - 1, 30720) : 0, (i < 7) ? 2'b01 : 2'b00));
    for (int i = 1; i <= 12; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (bus.audio_out !== AMP_W'(e.audio) || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL stop_mid cyc %0d audio_out=%0d busy=%b expected %0d/%b", i, $signed(bus.audio_out), bus.busy, e.audio, e.busy);
      end
      if (i == 6) bus.stop = 2'b01;
      if (i == 7) bus.stop = 2'b00;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_ch(0, 3, 15, 0);
    pulse(2'b01, 2'b00, 1'b0);
    for (int i = 1; i <= 14; i++)
      exp_q.push_back(mk((i <= 6) ? amp_at(i - 1, 30720) : amp_at(i - 7, 30720), 2'b01));
    for (int i = 1; i <= 14; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (bus.audio_out !== AMP_W'(e.audio) || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL retrigger cyc %0d audio_out=%0d busy=%b expected %0d/%b", i, $signed(bus.audio_out), bus.busy, e.audio, e.busy);
      end
      if (i == 5) bus.start = 2'b01;
      if (i == 6) bus.start = 2'b00;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_ch(0, 3, 15, 0);
    pulse(2'b01, 2'b00, 1'b0);
    repeat (6) cyc();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.audio_out !== '0 || bus.busy !== '0) begin
      errors++;
      $display("FAIL async_reset audio_out=%0d busy=%b expected 0/00", $signed(bus.audio_out), bus.busy);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) exp_q.push_back(mk(0, 2'b00));
    for (int i = 0; i < 20; i++) begin
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (bus.audio_out !== AMP_W'(e.audio) || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL after_reset cyc %0d audio_out=%0d busy=%b expected %0d/%b", i, $signed(bus.audio_out), bus.busy, e.audio, e.busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_mix();
    test_duration(5);
    test_duration(0);
    test_div_change();
    test_start_stop();
    test_back_to_back();
    test_async_reset();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover entries=%0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/buzzer_ctl_poly.md
Name: buzzer_ctl_poly

Overview:
Parametrised multi-channel square-wave tone generator. It replaces the single-voice buzzer driver in the speaker path.
- Each channel has its own note divider, 4-bit volume and note-duration timer, with start/stop control.
- Channels are summed with saturation into one signed PCM sample for the audio DAC serializer.
- The sequencer issues start pulses; a 1 ms strobe from the clock divider times note durations.

Parameters:
NUM_CH, 2, number of independent tone channels (1..8)
DIV_W, 22, width of each half-period divider value
VOL_W, 4, width of each channel volume
DUR_W, 12, width of each duration value, in tick units
AMP_W, 16, width of the signed mixed output sample

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-cycle duration strobe (nominally 1 ms)
note_div  input  NUM_CH*DIV_W  per-channel half-period minus 1, in clk cycles; channel c at [c*DIV_W +: DIV_W]; 0 = rest (silent)
volume  input  NUM_CH*VOL_W  per-channel amplitude step; 0 = silent
dur  input  NUM_CH*DUR_W  per-channel note length in ticks, sampled on start; 0 = infinite
start  input  NUM_CH  per-channel one-cycle pulse that begins a note
stop  input  NUM_CH  per-channel one-cycle pulse that ends a note
busy  output  NUM_CH  channel currently playing
audio_out  output  AMP_W  signed two's-complement mixed sample, registered

Behaviour:
- Reset (async, rst_n low): all counters = 0, all phases = 0, busy = 0, duration counters = 0, audio_out = 0.
- Per-channel state: div counter (DIV_W), phase bit, busy bit, duration counter (DUR_W), infinite flag.
- start[c]:
  - next cycle busy[c] = 1, div counter = 0, phase = 0;
  - duration counter = dur[c]; infinite flag = (dur[c] == 0).
  - start while busy restarts the note (retrigger).
- stop[c]: next cycle busy[c] = 0, counter = 0, phase = 0. start and stop in the same cycle: start wins.
- Duration countdown:
  - on tick with busy and not infinite, decrement the duration counter;
  - on the tick where it equals 1, busy clears (same clear as stop).
  - start coincident with tick: reload wins, no decrement.
- Divider (only while busy and note_div[c] != 0):
  - if counter >= note_div[c], counter = 0 and phase toggles; else counter + 1.
  - Half-period = note_div + 1 cycles.
  - The >= compare makes a lowered note_div take effect at once, with no 2^DIV_W wrap. A raised note_div extends the current half-period.
- note_div[c] == 0 while busy: counter held at 0, phase held, channel contributes 0; busy and duration unaffected.
- Channel amplitude:
  - A = volume[c] << (AMP_W-1-VOL_W); max 15<<11 = 30720 at defaults.
  - Contribution = +A when phase = 1, -A when phase = 0.
  - Contribution = 0 when not busy or note_div = 0.
- Mixer:
  - signed sum of all contributions in AMP_W+clog2(NUM_CH)+1 bits;
  - saturate to [-2^(AMP_W-1), 2^(AMP_W-1)-1];
  - registered into audio_out.
- Latency: audio_out reflects the phase/busy state one clk after that state updates, i.e. 2 cycles after the start pulse.
- volume and note_div are sampled live every cycle; only dur is latched at start.
- Mid-operation reset: immediate silence, all state cleared; no retained note after release.

Test Plan:
1. Reset released, no start -> audio_out = 0, busy = 0 for 100 cycles.
2. ch0 start, note_div=3, volume=15, dur=0 -> busy[0]=1 next cycle; audio_out alternates -30720 / +30720 with 4-cycle half-periods, first sample -30720 at cycle 2 after start.
3. ch0 and ch1 both note_div=3, volume=15, in phase -> audio_out saturates at -32768 / +32767. Change ch1 volume=1 -> audio_out becomes ±(30720+2048) = ±32767/-32768 clamp versus ±28672 when opposite phase (offset ch1 start by 4 cycles).
4. ch0 dur=3, tick every 10 cycles -> busy[0] drops on the 3rd tick after start and audio_out returns to 0 one cycle later. start coincident with a tick -> full 3 ticks honoured.
5. ch0 playing note_div=1000 with counter at 500; note_div changed to 100 -> toggle on the next cycle (500 >= 100), then 101-cycle half-periods.
6. start and stop same cycle -> note starts. stop alone mid-note -> busy=0, silence. rst_n low mid-note -> audio_out = 0 asynchronously, busy = 0.
